// File: rtl/output_sram_drain.sv
`default_nettype none
// ============================================================================
// Module      : output_sram_drain
// Description : Read-side sequencer for the pooled-output array. After a
//               layer completes, it walks every pooled output in row-major
//               order, OUTPUT_SRAM_LEN values per access. For each chunk it
//               issues one read to the pool array, captures the data that
//               returns one cycle later, and writes that chunk to the output
//               SRAM over a valid/ready port at consecutive addresses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock      in   system clock; all state changes on the rising edge
//   reset      in   synchronous, active-high
//   start      in   one-cycle pulse that begins a drain (ignored while busy)
//   base_addr  in   SRAM address of the first chunk, sampled on accepted start
//   pool_r_en  out  read request to the pool array (one cycle per chunk)
//   pool_r     out  row of the requested chunk
//   pool_c     out  first column of the requested chunk
//   pool_data  in   chunk data, valid the cycle after pool_r_en;
//                   lane i holds column pool_c+i
//   wr_valid   out  write request to the output SRAM
//   wr_ready   in   SRAM accepts the write when wr_valid & wr_ready
//   wr_addr    out  write address
//   wr_data    out  write data, lane order unchanged from pool_data
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the last chunk is accepted
// ============================================================================
module output_sram_drain #(
  parameter int OUTPUT_HEIGHT   = 8,
  parameter int OUTPUT_WIDTH    = 8,   // must be a multiple of OUTPUT_SRAM_LEN
  parameter int OUTPUT_SRAM_LEN = 4,
  parameter int BIN_LEN         = 16,
  parameter int ADDR_W          = 16,
  localparam int ROW_W  = (OUTPUT_HEIGHT > 1) ? $clog2(OUTPUT_HEIGHT) : 1,
  localparam int COL_W  = (OUTPUT_WIDTH  > 1) ? $clog2(OUTPUT_WIDTH)  : 1,
  localparam int DATA_W = BIN_LEN * OUTPUT_SRAM_LEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              pool_r_en,
  output logic [ROW_W-1:0]  pool_r,
  output logic [COL_W-1:0]  pool_c,
  input  logic [DATA_W-1:0] pool_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [ADDR_W-1:0]  addr;

  // Next chunk index and end-of-drain detection, all from registered state.
  logic [ROW_W-1:0]   next_row;
  logic [COL_W-1:0]   next_col;
  logic               row_wrap;
  logic               last_chunk;

  always_comb begin
    row_wrap   = (int'(col) + OUTPUT_SRAM_LEN >= OUTPUT_WIDTH);
    last_chunk = (int'(row) == OUTPUT_HEIGHT - 1) &&
                 (int'(col) == OUTPUT_WIDTH - OUTPUT_SRAM_LEN);
    next_row   = row;
    next_col   = col + COL_W'(OUTPUT_SRAM_LEN);
    if (row_wrap) begin
      next_col = '0;
      next_row = row + ROW_W'(1);
    end
  end

  // Single sequential FSM. Every output is a register, so the read request,
  // write request and done pulse are all glitch-free and change only on the
  // clock edge that enters the corresponding state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      addr      <= '0;
      pool_r_en <= 1'b0;
      pool_r    <= '0;
      pool_c    <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr      <= base_addr;
            row       <= '0;
            col       <= '0;
            // Entering ISSUE: the read request is presented for exactly
            // the one cycle spent in ISSUE.
            pool_r_en <= 1'b1;
            pool_r    <= '0;
            pool_c    <= '0;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          pool_r_en <= 1'b0;
          state     <= S_CAPTURE;
        end

        S_CAPTURE: begin
          // Data is passed through untouched, including any X/Z lanes.
          wr_data  <= pool_data;
          wr_addr  <= addr;
          wr_valid <= 1'b1;
          state    <= S_WRITE;
        end

        S_WRITE: begin
          // wr_addr/wr_data are not touched here, so they stay stable for
          // as long as the SRAM stalls.
          if (wr_ready) begin
            wr_valid <= 1'b0;
            addr     <= addr + ADDR_W'(1);
            if (last_chunk) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              row       <= next_row;
              col       <= next_col;
              pool_r    <= next_row;
              pool_c    <= next_col;
              pool_r_en <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          pool_r_en <= 1'b0;
          wr_valid  <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_sram_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_output_sram_drain
// Description : Directed self-checking bench for output_sram_drain with an
//               8x8 array, 4 lanes of 16 bits. A small pool model answers
//               each read with {row, column} per lane one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_sram_drain;

  localparam int H  = 8;
  localparam int W  = 8;
  localparam int L  = 4;
  localparam int B  = 16;
  localparam int AW = 16;
  localparam int DW = B * L;
  localparam int N  = H * W / L;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          pool_r_en;
  logic [2:0]    pool_r;
  logic [2:0]    pool_c;
  logic [DW-1:0] pool_data = '0;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  output_sram_drain #(
    .OUTPUT_HEIGHT  (H),
    .OUTPUT_WIDTH   (W),
    .OUTPUT_SRAM_LEN(L),
    .BIN_LEN        (B),
    .ADDR_W         (AW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .pool_r_en(pool_r_en),
    .pool_r   (pool_r),
    .pool_c   (pool_c),
    .pool_data(pool_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected chunk contents: lane i = {row, col+i}
  function automatic logic [DW-1:0] chunk(input int r, input int c);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < L; i++) d[i*B +: B] = {8'(r), 8'(c + i)};
    return d;
  endfunction

  // Pool array model: data appears the cycle after the read request.
  always @(posedge clock) begin
    if (pool_r_en)
      for (int i = 0; i < L; i++) pool_data[i*B +: B] <= {8'(pool_r), 8'(pool_c) + 8'(i)};
  end

  // Protocol monitor and write log, sampled on the falling edge.
  logic          prev_ren   = 1'b0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          prev_reset = 1'b1;
  logic          prev_done  = 1'b0;
  logic [AW-1:0] prev_addr  = '0;
  logic [DW-1:0] prev_data  = '0;
  int            drain_acc  = 0;
  int            done_count = 0;
  int            done_cyc   = -1;
  int            ren_count  = 0;
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];

  always @(negedge clock) begin
    if (pool_r_en) begin
      ren_count++;
      check("ren_single_cycle", prev_ren, 1'b0);
      check("ren_not_in_write", wr_valid, 1'b0);
      check("ren_while_busy", busy, 1'b1);
    end
    if (prev_valid && !prev_ready && !prev_reset) begin
      check("wr_hold_valid", wr_valid, 1'b1);
      check("wr_hold_addr", wr_addr, prev_addr);
      check("wr_hold_data", wr_data, prev_data);
    end
    if (done) begin
      check("done_single_cycle", prev_done, 1'b0);
      check("done_after_last_accept", drain_acc, N);
      done_count++;
      done_cyc  = cyc;
      drain_acc = 0;
    end
    if (reset) drain_acc = 0;
    if (wr_valid && wr_ready && !reset) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      drain_acc++;
    end
    prev_ren   = pool_r_en;
    prev_valid = wr_valid;
    prev_ready = wr_ready;
    prev_reset = reset;
    prev_done  = done;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
  end

  // Inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, output int t0);
    start     = 1'b1;
    base_addr = b;
    t0        = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_write(input logic [AW-1:0] a);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (wr_valid && wr_addr == a) ok = 1'b1;
      else tick();
    end
    check("reach_write_addr", ok, 1'b1);
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      tick();
      k++;
    end
    check("drain_finishes", busy, 1'b0);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic check_log(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    check("write_count", log_addr.size(), n);
    for (int k = 0; k < n && k < log_addr.size(); k++) begin
      a = base + AW'(k);
      check("wr_addr", log_addr[k], a);
      check("wr_data", log_data[k], chunk(k / 2, (k % 2) * 4));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pool_r_en"}, pool_r_en, 1'b0);
    check({tag, "_pool_r"}, pool_r, 3'd0);
    check({tag, "_pool_c"}, pool_c, 3'd0);
    check({tag, "_wr_valid"}, wr_valid, 1'b0);
    check({tag, "_wr_addr"}, wr_addr, 16'h0000);
    check({tag, "_wr_data"}, wr_data, 64'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  int t0;
  int dc;
  int rc;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    wr_ready  = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // T1: full drain, no backpressure
    clear_log();
    dc = done_count;
    pulse_start(16'h0100, t0);
    wait_idle(200);
    check_log(16'h0100, N);
    check("t1_done_cycle", done_cyc, t0 + 49);
    check("t1_done_count", done_count - dc, 1);

    // T2: backpressure for 5 cycles on chunk 3
    tick();
    clear_log();
    dc = done_count;
    pulse_start(16'h0100, t0);
    wait_write(16'h0103);
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t2_stall_valid", wr_valid, 1'b1);
      check("t2_stall_addr", wr_addr, 16'h0103);
      check("t2_stall_data", wr_data, chunk(1, 4));
      check("t2_stall_no_ren", pool_r_en, 1'b0);
      tick();
    end
    wr_ready = 1'b1;
    wait_idle(200);
    check_log(16'h0100, N);
    check("t2_done_cycle", done_cyc, t0 + 54);
    check("t2_done_count", done_count - dc, 1);

    // T3: start while busy is ignored
    tick();
    clear_log();
    dc = done_count;
    pulse_start(16'h0100, t0);
    wait_write(16'h0106);
    start     = 1'b1;
    base_addr = 16'h0200;
    tick();
    start = 1'b0;
    wait_idle(200);
    check_log(16'h0100, N);
    check("t3_done_cycle", done_cyc, t0 + 49);
    check("t3_done_count", done_count - dc, 1);

    // T4: reset during chunk 9 write aborts, then a clean drain
    tick();
    clear_log();
    dc = done_count;
    pulse_start(16'h0100, t0);
    wait_write(16'h0109);
    reset = 1'b1;
    tick();
    check_all_zero("t4_abort");
    reset = 1'b0;
    rc = ren_count;
    repeat (10) tick();
    check("t4_no_done", done_count - dc, 0);
    check("t4_no_ren", ren_count - rc, 0);
    check("t4_idle", busy, 1'b0);
    check("t4_partial_writes", log_addr.size(), 9);
    clear_log();
    pulse_start(16'h0000, t0);
    wait_idle(200);
    check_log(16'h0000, N);
    check("t4_done_cycle", done_cyc, t0 + 49);
    check("t4_done_count", done_count - dc, 1);

    // T5: reset wins over start, then a wrapping drain
    tick();
    reset     = 1'b1;
    start     = 1'b1;
    base_addr = 16'h1234;
    tick();
    reset = 1'b0;
    start = 1'b0;
    rc    = ren_count;
    repeat (5) tick();
    check("t5_no_ren", ren_count - rc, 0);
    check("t5_idle", busy, 1'b0);
    check("t5_no_write", wr_valid, 1'b0);
    clear_log();
    dc = done_count;
    pulse_start(16'hFFFE, t0);
    wait_idle(200);
    check_log(16'hFFFE, N);
    check("t5_done_count", done_count - dc, 1);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
